// File: rtl/btc_host_responder_if.sv
// Byte handshake between the host responder and the SHA256d mining core.
// master = responder side (drives start/rdy/data), slave = core side.
interface btc_host_responder_if;
  logic       chip_start;
  logic       chip_rdy;
  logic [7:0] chip_data;
  logic [7:0] chip_uo;
  logic       chip_rq;
  logic       chip_done;

  modport master (
    output chip_start, chip_rdy, chip_data,
    input  chip_uo, chip_rq, chip_done
  );

  modport slave (
    input  chip_start, chip_rdy, chip_data,
    output chip_uo, chip_rq, chip_done
  );
endinterface

// File: rtl/btc_host_responder.sv
// Host responder: serves message bytes to the mining core and collects its 256-bit hash.
// Optional macro LZ_CHECK_EN adds leading-zero count and hit outputs.
module btc_host_responder #(
  parameter int MEM_BYTES      = 128,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LZ_TARGET      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_we,
  input  logic [6:0]   ld_addr,
  input  logic [7:0]   ld_data,
  input  logic         go,
  output logic         busy,
  output logic         result_valid,
  output logic         err,
  output logic [255:0] hash,
`ifdef LZ_CHECK_EN
  output logic [8:0]   lz_count,
  output logic         hit,
`endif
  btc_host_responder_if.master chip
);

  localparam int         AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [7:0] MEM_LIM = 8'(MEM_BYTES);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, SERVE, COLLECT, FINISH} state_t;

  state_t      state;
  logic [5:0]  n;
  logic [15:0] wdog;
  logic [7:0]  mem [MEM_BYTES];

  logic       ack, rq_fall, ld_ok, rd_ok;
  logic [7:0] rd_byte;

  // A new request is only taken once rdy from the previous one has been withdrawn.
  assign ack     = chip.chip_rq && !chip.chip_rdy;
  assign rq_fall = !chip.chip_rq && chip.chip_rdy;
  assign ld_ok   = ld_we && !busy && ({1'b0, ld_addr} < MEM_LIM);
  assign rd_ok   = {1'b0, chip.chip_uo[6:0]} < MEM_LIM;
  assign rd_byte = rd_ok ? mem[chip.chip_uo[AW-1:0]] : 8'h00;

  always_ff @(posedge clk)
    if (ld_ok) mem[ld_addr[AW-1:0]] <= ld_data;

`ifdef LZ_CHECK_EN
  logic [8:0] lz_comb;
  always_comb begin
    lz_comb = 9'd256;
    for (int i = 0; i < 256; i++)
      if (hash[i]) lz_comb = 9'(255 - i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      n               <= '0;
      wdog            <= '0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      err             <= 1'b0;
      hash            <= '0;
      chip.chip_start <= 1'b0;
      chip.chip_rdy   <= 1'b0;
      chip.chip_data  <= '0;
`ifdef LZ_CHECK_EN
      lz_count        <= '0;
      hit             <= 1'b0;
`endif
    end else begin
      chip.chip_start <= 1'b0;
      result_valid    <= 1'b0;
      if (!chip.chip_rq) chip.chip_rdy <= 1'b0;

      if (busy && !rq_fall && wdog == WD_LAST) begin
        err           <= 1'b1;
        chip.chip_rdy <= 1'b0;
        busy          <= 1'b0;
        wdog          <= '0;
        state         <= IDLE;
      end else begin
        if (busy) wdog <= rq_fall ? 16'd0 : wdog + 16'd1;
        case (state)
          IDLE: if (go) begin
            err             <= 1'b0;
            n               <= '0;
            wdog            <= '0;
            busy            <= 1'b1;
            chip.chip_start <= 1'b1;
            state           <= START;
          end
          START: state <= SERVE;
          SERVE: begin
            if (chip.chip_done) state <= COLLECT;
            else if (ack) begin
              chip.chip_data <= rd_byte;
              chip.chip_rdy  <= 1'b1;
            end
          end
          COLLECT: begin
            if (n == 6'd32 && !chip.chip_done) state <= FINISH;
            else if (ack) begin
              // Bytes beyond the 32nd are acknowledged so the core never stalls, then dropped.
              if (n != 6'd32) begin
                hash[{5'd31 - n[4:0], 3'b000} +: 8] <= chip.chip_uo;
                n <= n + 6'd1;
              end
              chip.chip_rdy <= 1'b1;
            end
          end
          FINISH: begin
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
`ifdef LZ_CHECK_EN
            lz_count     <= lz_comb;
            hit          <= (lz_comb >= 9'(LZ_TARGET));
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btc_host_responder.sv
// Randomized bench for btc_host_responder: core-side handshake model plus reference buffer/hash model.
module tb_btc_host_responder;
  localparam int MEMB = 64;
  localparam int TO   = 16;

  logic         clk = 1'b0, rst_n = 1'b0, ld_we = 1'b0, go = 1'b0;
  logic [6:0]   ld_addr = '0;
  logic [7:0]   ld_data = '0;
  logic         busy, result_valid, err;
  logic [255:0] hash;
`ifdef LZ_CHECK_EN
  logic [8:0]   lz_count;
  logic         hit;
`endif

  btc_host_responder_if bus();

  btc_host_responder #(.MEM_BYTES(MEMB), .TIMEOUT_CYCLES(TO), .LZ_TARGET(32)) dut (
    .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .go(go), .busy(busy), .result_valid(result_valid), .err(err), .hash(hash),
`ifdef LZ_CHECK_EN
    .lz_count(lz_count), .hit(hit),
`endif
    .chip(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int rv_cnt = 0, st_cnt = 0, rv0, st0;
  logic [7:0] mm [0:127];
  logic [7:0] hb [0:32];

  always @(posedge clk) begin
    if (result_valid)   rv_cnt <= rv_cnt + 1;
    if (bus.chip_start) st_cnt <= st_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic ld(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    if (int'(a) < MEMB) mm[a] = d;
  endtask

  task automatic start_run();
    st0 = st_cnt;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_start", bus.chip_start, 1);
    chk("go_err_clr", err, 0);
  endtask

  // One four-phase transfer from the core side; rdy must be low when rq is raised.
  task automatic xfer(input logic [7:0] uo, input bit chk_data, input logic [7:0] exp);
    int k;
    @(negedge clk);
    chk("rdy_pre", bus.chip_rdy, 0);
    bus.chip_rq = 1'b1; bus.chip_uo = uo;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.chip_rdy && k < 8);
    chk("rdy_lat", k, 1);
    if (chk_data) chk("data", bus.chip_data, exp);
    bus.chip_rq = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic serve(input logic [6:0] a);
    xfer({1'b0, a}, 1'b1, (int'(a) < MEMB) ? mm[a] : 8'h00);
  endtask

  task automatic collect(input int nbytes);
    logic [255:0] exp_h;
    int k, exp_lz;
    bus.chip_done = 1'b1;
    exp_h = '0;
    for (int i = 0; i < nbytes; i++) begin
      xfer(hb[i], 1'b0, 8'h00);
      if (i < 32) exp_h = {exp_h[247:0], hb[i]};
    end
    bus.chip_done = 1'b0;
    rv0 = rv_cnt;
    k = 0;
    do begin @(negedge clk); k++; end while (!result_valid && k < 10);
    chk("rv_seen", result_valid, 1);
    chk("hash", hash, exp_h);
    chk("busy_end", busy, 0);
    exp_lz = 256;
    for (int b = 255; b >= 0; b--)
      if (exp_h[b]) begin exp_lz = 255 - b; break; end
`ifdef LZ_CHECK_EN
    chk("lz_count", lz_count, exp_lz);
    chk("hit", hit, (exp_lz >= 32) ? 1 : 0);
`endif
    repeat (3) @(negedge clk);
    chk("rv_once", rv_cnt - rv0, 1);
    chk("start_once", st_cnt - st0, 1);
    chk("hash_hold", hash, exp_h);
  endtask

  task automatic timeout_run(input bit hold_rq);
    int k;
    rv0 = rv_cnt;
    start_run();
    if (hold_rq) begin bus.chip_rq = 1'b1; bus.chip_uo = 8'h02; end
    k = 0;
    while (!err && k < 40) begin @(negedge clk); k++; end
    chk("to_cycles", k, TO);
    chk("to_busy", busy, 0);
    chk("to_rdy", bus.chip_rdy, 0);
    bus.chip_rq = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_no_rv", rv_cnt - rv0, 0);
    chk("to_err_sticky", err, 1);
  endtask

  initial begin
    bus.chip_rq = 1'b0; bus.chip_uo = '0; bus.chip_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_hash", hash, 0);
    chk("rst_start", bus.chip_start, 0);
    chk("rst_rdy", bus.chip_rdy, 0);
    chk("rst_data", bus.chip_data, 0);
`ifdef LZ_CHECK_EN
    chk("rst_lz", lz_count, 0);
    chk("rst_hit", hit, 0);
`endif
    rst_n = 1'b1;

    // Run A: incrementing buffer, fixed then random addresses, hash A0..BF.
    for (int i = 0; i < 128; i++) ld(7'(i), 8'(i));
    start_run();
    for (int i = 0; i < 4; i++) serve(7'(i));
    @(negedge clk); ld_we = 1'b1; ld_addr = 7'd5; ld_data = 8'hEE;
    @(negedge clk); ld_we = 1'b0;
    serve(7'd5);
    serve(7'h7F);
    for (int i = 0; i < 58; i++) serve(7'($urandom_range(0, 127)));
    for (int i = 0; i < 32; i++) hb[i] = 8'(8'hA0 + i);
    collect(32);

    timeout_run(1'b0);

    // Run B: random buffer, leading-zero pattern, one extra byte after the 32nd.
    for (int i = 0; i < 128; i++) ld(7'(i), 8'($urandom));
    start_run();
    for (int i = 0; i < 20; i++) serve(7'($urandom_range(0, 127)));
    for (int i = 0; i < 33; i++) hb[i] = 8'($urandom);
    hb[0] = 8'h00; hb[1] = 8'h00; hb[2] = 8'h00; hb[3] = 8'h00; hb[4] = 8'h0F;
    collect(33);

    timeout_run(1'b1);

    // Run C: chip_done already high when go arrives.
    bus.chip_done = 1'b1;
    start_run();
    @(negedge clk);
    for (int i = 0; i < 32; i++) hb[i] = 8'($urandom);
    hb[0] = 8'h80;
    collect(32);

    // Run D: fully random.
    start_run();
    for (int i = 0; i < 16; i++) serve(7'($urandom_range(0, 127)));
    for (int i = 0; i < 32; i++) hb[i] = 8'($urandom);
    collect(32);

    // Run E: all-zero hash.
    start_run();
    serve(7'd9);
    for (int i = 0; i < 32; i++) hb[i] = 8'h00;
    collect(32);

    // Reset pulsed while a served byte is still acknowledged.
    rv0 = rv_cnt;
    start_run();
    bus.chip_rq = 1'b1; bus.chip_uo = 8'h03;
    repeat (2) @(negedge clk);
    chk("prerst_rdy", bus.chip_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rdy", bus.chip_rdy, 0);
    chk("mrst_start", bus.chip_start, 0);
    chk("mrst_err", err, 0);
    chk("mrst_rv", result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.chip_rq = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_no_rv", rv_cnt - rv0, 0);
    chk("mrst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/btc_host_responder.md
Name: btc_host_responder

Overview:
- Host-side responder for the SHA256d mining core's byte handshake: holds the message bytes the core requests and returns them one byte per handshake.
- Collects the 32 hash bytes the core emits, then presents the full 256-bit hash to local logic.
- Sits in the same clock domain as the core, on the FPGA/test-harness side of the pads.
- Drives the core's start, rdy and data inputs; observes its rq, done and 8-bit output bus.

Parameters:
- MEM_BYTES, 128, message buffer depth in bytes; addresses 0..MEM_BYTES-1 are valid, max 128.
- TIMEOUT_CYCLES, 65535, idle cycles allowed between completed handshakes before abort; 16-bit counter.
- LZ_TARGET, 32, leading-zero-bit threshold for hit (LZ_CHECK_EN only).

Ports:
- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- ld_we  in  1  buffer write strobe, ignored while busy.
- ld_addr  in  7  buffer byte address.
- ld_data  in  8  buffer write data.
- go  in  1  start one hash run, ignored while busy.
- busy  out  1  run in progress.
- result_valid  out  1  one-cycle pulse when hash is complete.
- err  out  1  sticky timeout flag, cleared by the next accepted go.
- hash  out  256  captured hash; first received byte is hash[255:248].
- chip_start  out  1  to core start.
- chip_rdy  out  1  to core rdy.
- chip_data  out  8  to core data input.
- chip_uo  in  8  core output bus: byte address {0, word[4:0], byte[1:0]} when chip_done=0, hash byte when chip_done=1.
- chip_rq  in  1  core request.
- chip_done  in  1  core output phase.
- lz_count  out  9  leading zero bits of hash, 0..256 (LZ_CHECK_EN only).
- hit  out  1  lz_count >= LZ_TARGET, valid with result_valid (LZ_CHECK_EN only).

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, watchdog 0. Buffer contents are not reset.
- Reset mid-run aborts immediately with no result_valid.
- Buffer writes: when ld_we=1 and not busy, mem[ld_addr] <= ld_data. Writes with ld_addr >= MEM_BYTES are dropped.
- States:
  - IDLE: on go, clear err and byte counter, then enter START with busy=1.
  - START: drive chip_start=1 for exactly one cycle, then enter SERVE.
  - SERVE (chip_done=0):
    - When chip_rq=1 and chip_rdy=0 are sampled: register chip_data <= mem[chip_uo[6:0]] (8'h00 if the address is >= MEM_BYTES) and set chip_rdy <= 1.
    - This gives a 1-cycle latency from the rq sample to rdy+data.
    - chip_data holds until the next request.
    - When chip_done=1 is sampled, enter COLLECT; SERVE is exited regardless of rq.
  - COLLECT: when chip_rq=1 and chip_rdy=0 are sampled, capture chip_uo into hash byte [255-8n -: 8], increment n, and set chip_rdy <= 1.
  - When n==32 and chip_done is sampled 0, enter FINISH.
  - FINISH: pulse result_valid for one cycle, drop busy, return to IDLE. hash holds until the next accepted go.
- Four-phase rule, all states: chip_rdy <= 0 in any cycle where chip_rq is sampled 0. chip_rdy is never raised in the same cycle rq is seen low.
  - Once rdy=1, it is held while rq stays 1.
  - This guarantees the core never sees stale rdy on its next request.
- Extra bytes: a request in COLLECT with n==32 is still acknowledged, but its data is discarded.
- Watchdog:
  - Counts cycles while busy.
  - Cleared on every cycle that rq is sampled falling with rdy=1.
  - On reaching TIMEOUT_CYCLES: set err, force chip_rdy=0, drop busy, go to IDLE with no result_valid.
- go and chip_done arriving in the same IDLE cycle: go wins; a stale chip_done is handled by the COLLECT path.

Optional Feature:
- Macro LZ_CHECK_EN.
- When defined:
  - A combinational priority encoder over the captured hash produces lz_count.
  - lz_count is registered in FINISH.
  - hit = (lz_count >= LZ_TARGET).
  - Both are valid in the result_valid cycle and held until the next go.
- When undefined: lz_count and hit ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Load mem[i]=i for 0..127, go → one chip_start pulse. Core model requests addresses 0,1,2,3 → chip_data 0x00,0x01,0x02,0x03, each with chip_rdy exactly 1 cycle after rq is seen.
- Core model drops rq and re-raises it the next cycle → chip_rdy is low in the cycle the model sees rq high again. No double-consume; every served byte is correct for 64 consecutive requests.
- chip_done rises and the model emits bytes 0xA0..0xBF → hash = 0xA0A1...BF, result_valid pulses once after done falls, busy=0.
- Request address 0x7F with MEM_BYTES=64 → chip_data=0x00. A ld_we during busy leaves the buffer unchanged.
- TIMEOUT_CYCLES=16 and the model stalls with rq=0 → err=1 at cycle 16, busy=0, no result_valid. A following go clears err.
- LZ_CHECK_EN, hash=0x00000000_0F.. → lz_count=36; LZ_TARGET=32 → hit=1. Hash 0x80.. → lz_count=0, hit=0.
- rst_n pulsed low mid-SERVE → chip_rdy, chip_start, busy and err all 0 immediately, with no result_valid.
